// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 memory arbiter.
//   state_t        : transfer FSM states
//   CMD_*_BIT      : bit positions inside the command byte
//   REQ_*          : requester index inside the two-bit req/gnt vectors
//   BYTES_PER_WORD : beats per word-sized bus phase
//   cmd_byte()     : builds the command byte sent in the CMD beat
package mic1_pkg;

   localparam int BYTES_PER_WORD = 4;

   localparam int CMD_WE_BIT   = 0;
   localparam int CMD_WORD_BIT = 1;

   localparam int REQ_FETCH = 0;
   localparam int REQ_DATA  = 1;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WDATA,
      RDATA,
      DONE
   } state_t;

   function automatic logic [7:0] cmd_byte(input logic word, input logic we);
      logic [7:0] b;
      b               = 8'h00;
      b[CMD_WORD_BIT] = word;
      b[CMD_WE_BIT]   = we;
      return b;
   endfunction

endpackage

// File: rtl/mic1_rr_arbiter.sv
// Two-way round-robin arbiter between instruction fetch and data access.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests, indexed by REQ_FETCH / REQ_DATA
//   en         : an arbitration slot is open this cycle
//   gnt[1:0]   : one-hot grant, valid only while en is high
// last_data remembers who was served last; it resets to "data" so fetch
// wins the first tie after reset.
module mic1_rr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);
   import mic1_pkg::*;

   logic last_data;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[REQ_FETCH] && req[REQ_DATA]) begin
            // Tie: whoever was not served last goes next.
            if (last_data) gnt[REQ_FETCH] = 1'b1;
            else           gnt[REQ_DATA]  = 1'b1;
         end else if (req[REQ_FETCH]) begin
            gnt[REQ_FETCH] = 1'b1;
         end else if (req[REQ_DATA]) begin
            gnt[REQ_DATA] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    last_data <= 1'b1;
      else if (|gnt) last_data <= gnt[REQ_DATA];
   end

endmodule

// File: rtl/mic1_mem_arbiter.sv
// MIC-1 memory arbiter: shares one external byte bus between the PC-driven
// instruction fetch port and the MAR/MDR-driven data port.
// Each transfer is: CMD (1 beat) -> ADDR (4 beats, LSB first) ->
// WDATA (4 beats) or RDATA (4 beats for data, 1 beat for fetch) -> DONE.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   fetch_req/addr, fetch_gnt/done : fetch port, fetch_rdata is one byte
//   data_req/we/addr/wdata         : data port request (word access)
//   data_gnt/done, data_rdata      : data port responses
//   bus_out/bus_oe                 : outbound byte and its valid
//   bus_in/bus_rd                  : inbound byte and "read beat expected"
//   ext_ready                      : external side completes the current beat
module mic1_mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int BYTES_PER_WORD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_done,
   output logic [7:0]        fetch_rdata,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_gnt,
   output logic              data_done,
   output logic [31:0]       data_rdata,
   output logic [7:0]        bus_out,
   output logic              bus_oe,
   input  logic [7:0]        bus_in,
   output logic              bus_rd,
   input  logic              ext_ready
);
   import mic1_pkg::*;

   localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

   state_t            state, state_nx;
   logic [1:0]        cnt, cnt_nx;
   logic [1:0]        gnt;
   logic              arb_en;
   logic              serve_data;
   logic              serve_we;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [23:0]       rbuf;

   // Grants are combinational in IDLE so the winner sees gnt in the same
   // cycle it is accepted; rst_n gates them so reset forces gnt low at once.
   assign arb_en = (state == IDLE) && rst_n;

   mic1_rr_arbiter u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({data_req, fetch_req}),
      .en    (arb_en),
      .gnt   (gnt)
   );

   assign fetch_gnt = gnt[REQ_FETCH];
   assign data_gnt  = gnt[REQ_DATA];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // In every beat-carrying state bus_oe or bus_rd is already 1, so a
   // completed beat reduces to ext_ready there.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bus_out    = 8'h00;
      bus_oe     = 1'b0;
      bus_rd     = 1'b0;
      fetch_done = 1'b0;
      data_done  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = 2'd0;
            if (|gnt) state_nx = CMD;
         end
         CMD: begin
            bus_out = cmd_byte(serve_data, serve_we);
            bus_oe  = 1'b1;
            if (ext_ready) state_nx = ADDR;
         end
         ADDR: begin
            bus_out = addr_q[{cnt, 3'b000} +: 8];
            bus_oe  = 1'b1;
            if (ext_ready) begin
               cnt_nx = cnt + 2'd1;
               if (cnt == LAST_BEAT) begin
                  cnt_nx   = 2'd0;
                  state_nx = (serve_data && serve_we) ? WDATA : RDATA;
               end
            end
         end
         WDATA: begin
            bus_out = wdata_q[{cnt, 3'b000} +: 8];
            bus_oe  = 1'b1;
            if (ext_ready) begin
               cnt_nx = cnt + 2'd1;
               if (cnt == LAST_BEAT) begin
                  cnt_nx   = 2'd0;
                  state_nx = DONE;
               end
            end
         end
         RDATA: begin
            bus_rd = 1'b1;
            if (ext_ready) begin
               cnt_nx = cnt + 2'd1;
               // A fetch reads a single opcode/operand byte.
               if (!serve_data || cnt == LAST_BEAT) begin
                  cnt_nx   = 2'd0;
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            fetch_done = !serve_data;
            data_done  = serve_data;
            state_nx   = IDLE;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 2'd0;
         end
      endcase
   end

   // Transaction context, captured at the grant; meaningless while idle.
   always_ff @(posedge clk) begin
      if (state == IDLE && (|gnt)) begin
         serve_data <= gnt[REQ_DATA];
         serve_we   <= gnt[REQ_DATA] & data_we;
         addr_q     <= gnt[REQ_DATA] ? data_addr : fetch_addr;
         wdata_q    <= data_wdata;
      end
      if (state == RDATA && ext_ready) begin
         case (cnt)
            2'd0:    rbuf[7:0]   <= bus_in;
            2'd1:    rbuf[15:8]  <= bus_in;
            2'd2:    rbuf[23:16] <= bus_in;
            default: ;
         endcase
      end
   end

   // Read results only update on the beat that ends the read, so each
   // output keeps its previous value until its own done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_rdata <= 8'h00;
         data_rdata  <= 32'h0;
      end else if (state == RDATA && ext_ready) begin
         if (!serve_data)            fetch_rdata <= bus_in;
         else if (cnt == LAST_BEAT) data_rdata  <= {bus_in, rbuf};
      end
   end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Testbench for mic1_mem_arbiter: a transaction-level model (queue of
// expected bus beats per transfer) checked against the DUT every cycle,
// plus directed transfers with literal expectations.
module tb_mic1_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_gnt, fetch_done;
   logic [7:0]  fetch_rdata;
   logic        data_req, data_we;
   logic [31:0] data_addr, data_wdata;
   logic        data_gnt, data_done;
   logic [31:0] data_rdata;
   logic [7:0]  bus_out;
   logic        bus_oe;
   logic [7:0]  bus_in;
   logic        bus_rd;
   logic        ext_ready;

   always #5 clk = ~clk;

   mic1_mem_arbiter #(.ADDR_W(32), .BYTES_PER_WORD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_gnt   (fetch_gnt),
      .fetch_done  (fetch_done),
      .fetch_rdata (fetch_rdata),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_done   (data_done),
      .data_rdata  (data_rdata),
      .bus_out     (bus_out),
      .bus_oe      (bus_oe),
      .bus_in      (bus_in),
      .bus_rd      (bus_rd),
      .ext_ready   (ext_ready)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic       oe;
      logic       rd;
      logic [7:0] b;
      int         lane;
   } beat_t;

   // Model: 0 = free, 1 = beats pending in m_q, 2 = done cycle
   beat_t       m_q[$];
   int          m_phase     = 0;
   logic        m_who       = 1'b0;
   logic        m_last_data = 1'b1;
   logic [31:0] m_rbuf      = 32'h0;
   logic [7:0]  m_frd       = 8'h00;
   logic [31:0] m_drd       = 32'h0;

   // Observations of the DUT
   logic [7:0] bus_log[$];
   int         gnt_log[$];
   int n_fgnt = 0, n_dgnt = 0, n_fdone = 0, n_ddone = 0;
   int fgnt_cyc = 0, dgnt_cyc = 0, fdone_cyc = 0, ddone_cyc = 0;
   int rd_idx = 0;

   // External device behaviour
   bit         rand_mode = 1'b0;
   int         stall_lo  = 0;
   int         stall_hi  = 0;
   logic [7:0] pat[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic        efg, edg, efd, edd, eoe, erd, win_data;
      logic [7:0]  eout;
      logic [31:0] a;
      beat_t       b;
      efg = 0; edg = 0; efd = 0; edd = 0; eoe = 0; erd = 0; eout = 8'h00;
      win_data = 0;
      if (!rst_n) begin
         m_q.delete();
         m_phase = 0; m_last_data = 1'b1; m_frd = 8'h00; m_drd = 32'h0;
      end else if (m_phase == 0) begin
         if (fetch_req || data_req) begin
            win_data = data_req && (!fetch_req || !m_last_data);
            efg = !win_data;
            edg = win_data;
         end
      end else if (m_phase == 1) begin
         eoe  = m_q[0].oe;
         erd  = m_q[0].rd;
         eout = m_q[0].oe ? m_q[0].b : 8'h00;
      end else begin
         efd = !m_who;
         edd = m_who;
      end

      chk("fetch_gnt", fetch_gnt, efg);
      chk("data_gnt", data_gnt, edg);
      chk("fetch_done", fetch_done, efd);
      chk("data_done", data_done, edd);
      chk("bus_oe", bus_oe, eoe);
      chk("bus_rd", bus_rd, erd);
      chk("bus_out", bus_out, eout);
      chk("fetch_rdata", fetch_rdata, m_frd);
      chk("data_rdata", data_rdata, m_drd);

      if (fetch_gnt) begin n_fgnt++; fgnt_cyc = cyc; gnt_log.push_back(0); rd_idx = 0; end
      if (data_gnt)  begin n_dgnt++; dgnt_cyc = cyc; gnt_log.push_back(1); rd_idx = 0; end
      if (fetch_done) begin n_fdone++; fdone_cyc = cyc; end
      if (data_done)  begin n_ddone++; ddone_cyc = cyc; end
      if (ext_ready && bus_oe) bus_log.push_back(bus_out);
      if (ext_ready && bus_rd) rd_idx++;

      if (rst_n) begin
         if (m_phase == 0) begin
            if (fetch_req || data_req) begin
               a = win_data ? data_addr : fetch_addr;
               m_who = win_data; m_last_data = win_data; m_rbuf = 32'h0;
               m_q.push_back('{oe:1'b1, rd:1'b0, b:{6'b0, win_data, win_data & data_we}, lane:0});
               for (int i = 0; i < 4; i++)
                  m_q.push_back('{oe:1'b1, rd:1'b0, b:a[8*i +: 8], lane:i});
               if (win_data && data_we) begin
                  for (int i = 0; i < 4; i++)
                     m_q.push_back('{oe:1'b1, rd:1'b0, b:data_wdata[8*i +: 8], lane:i});
               end else if (win_data) begin
                  for (int i = 0; i < 4; i++)
                     m_q.push_back('{oe:1'b0, rd:1'b1, b:8'h00, lane:i});
               end else begin
                  m_q.push_back('{oe:1'b0, rd:1'b1, b:8'h00, lane:0});
               end
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (ext_ready) begin
               b = m_q.pop_front();
               if (b.rd) m_rbuf[8*b.lane +: 8] = bus_in;
               if (m_q.size() == 0) begin
                  if (!m_who)    m_frd = bus_in;
                  else if (b.rd) m_drd = m_rbuf;
                  m_phase = 2;
               end
            end
         end else begin
            m_phase = 0;
         end
      end
   endtask

   task automatic drive_dev();
      if (rand_mode) begin
         ext_ready = ($urandom_range(0, 3) != 0);
         bus_in    = 8'($urandom);
      end else begin
         ext_ready = !(cyc >= stall_lo && cyc < stall_hi);
         bus_in    = pat[rd_idx % 4];
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      drive_dev();
   endtask

   // Issues one request, holds it until its grant, waits for its done and
   // returns the grant-to-done distance in cycles.
   task automatic do_xfer(input bit is_data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
      int ng0, nd0, i;
      ng0 = is_data ? n_dgnt : n_fgnt;
      nd0 = is_data ? n_ddone : n_fdone;
      if (is_data) begin
         data_we = we; data_addr = addr; data_wdata = wdata; data_req = 1'b1;
      end else begin
         fetch_addr = addr; fetch_req = 1'b1;
      end
      i = 0;
      do begin step(); i++; end
      while (((is_data ? n_dgnt : n_fgnt) == ng0) && i < 50);
      fetch_req = 1'b0;
      data_req  = 1'b0;
      chk("grant within bound", ((is_data ? n_dgnt : n_fgnt) != ng0), 1);
      i = 0;
      while (((is_data ? n_ddone : n_fdone) == nd0) && i < 100) begin step(); i++; end
      chk("done within bound", ((is_data ? n_ddone : n_fdone) != nd0), 1);
      lat = is_data ? (ddone_cyc - dgnt_cyc) : (fdone_cyc - fgnt_cyc);
   endtask

   initial begin
      logic [7:0] exp22[5];
      logic [7:0] exp23[9];
      int lat, nd0, i, ngf, ngd;
      bit pf, pd;

      rst_n = 1'b0;
      fetch_req = 0; fetch_addr = 0;
      data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
      bus_in = 0; ext_ready = 1'b1;
      pat[0] = 8'h00; pat[1] = 8'h00; pat[2] = 8'h00; pat[3] = 8'h00;

      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Fetch of 0x104
      exp22[0] = 8'h00; exp22[1] = 8'h04; exp22[2] = 8'h01; exp22[3] = 8'h00; exp22[4] = 8'h00;
      pat[0] = 8'hA7;
      bus_log.delete();
      do_xfer(1'b0, 1'b0, 32'h0000_0104, 32'h0, lat);
      chk("fetch latency", lat, 7);
      chk("fetch rdata", fetch_rdata, 8'hA7);
      chk("fetch byte count", bus_log.size(), 5);
      for (int k = 0; k < 5 && k < bus_log.size(); k++) chk("fetch bus byte", bus_log[k], exp22[k]);

      // Data write 0xDEADBEEF to 0x10
      exp23[0] = 8'h03; exp23[1] = 8'h10; exp23[2] = 8'h00; exp23[3] = 8'h00; exp23[4] = 8'h00;
      exp23[5] = 8'hEF; exp23[6] = 8'hBE; exp23[7] = 8'hAD; exp23[8] = 8'hDE;
      bus_log.delete();
      do_xfer(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat);
      chk("write latency", lat, 10);
      chk("write byte count", bus_log.size(), 9);
      for (int k = 0; k < 9 && k < bus_log.size(); k++) chk("write bus byte", bus_log[k], exp23[k]);

      // Data read with a 3-cycle stall in the middle of ADDR
      pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
      stall_lo = cyc + 3;
      stall_hi = cyc + 6;
      bus_log.delete();
      do_xfer(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat);
      stall_lo = 0; stall_hi = 0;
      chk("stalled read latency", lat, 13);
      chk("read rdata", data_rdata, 32'h4433_2211);
      chk("fetch rdata held", fetch_rdata, 8'hA7);
      chk("read cmd byte", bus_log.size() > 0 ? bus_log[0] : 8'hFF, 8'h02);

      // Both requesters high continuously, from a fresh reset
      rst_n = 1'b0;
      repeat (2) step();
      chk("rdata cleared by reset", data_rdata, 32'h0);
      rst_n = 1'b1;
      gnt_log.delete();
      fetch_addr = 32'h0000_0200; data_addr = 32'h0000_0300; data_we = 1'b0;
      fetch_req = 1'b1; data_req = 1'b1;
      repeat (60) step();
      fetch_req = 1'b0; data_req = 1'b0;
      repeat (20) step();
      chk("alternating grant count", gnt_log.size() >= 4, 1);
      for (int k = 0; k < gnt_log.size(); k++) chk("alternating grant", gnt_log[k], k % 2);

      // Reset in the middle of a write (WDATA beat 2)
      nd0 = n_ddone;
      data_we = 1'b1; data_addr = 32'h0000_0040; data_wdata = 32'h1234_5678; data_req = 1'b1;
      ngd = n_dgnt;
      i = 0;
      do begin step(); i++; end while (n_dgnt == ngd && i < 50);
      data_req = 1'b0;
      chk("reset-test grant", n_dgnt != ngd, 1);
      i = 0;
      while (cyc < dgnt_cyc + 8 && i < 50) begin step(); i++; end
      chk("in WDATA before reset", bus_oe, 1);
      rst_n = 1'b0;
      #1;
      chk("reset bus_oe", bus_oe, 0);
      chk("reset bus_rd", bus_rd, 0);
      chk("reset bus_out", bus_out, 8'h00);
      chk("reset data_done", data_done, 0);
      chk("reset fetch_rdata", fetch_rdata, 8'h00);
      chk("reset data_rdata", data_rdata, 32'h0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("no done after abort", n_ddone, nd0);
      pat[0] = 8'h5C;
      do_xfer(1'b0, 1'b0, 32'h0000_0ABC, 32'h0, lat);
      chk("post-reset fetch latency", lat, 7);
      chk("post-reset fetch rdata", fetch_rdata, 8'h5C);

      // Randomised traffic against the model
      rand_mode = 1'b1;
      pf = 0; pd = 0; ngf = n_fgnt; ngd = n_dgnt;
      for (int n = 0; n < 3000; n++) begin
         step();
         if (pf && n_fgnt != ngf) begin fetch_req = 1'b0; pf = 0; end
         if (pd && n_dgnt != ngd) begin data_req = 1'b0; pd = 0; end
         if (!pf && $urandom_range(0, 2) == 0) begin
            fetch_addr = $urandom; fetch_req = 1'b1; pf = 1; ngf = n_fgnt;
         end
         if (!pd && $urandom_range(0, 2) == 0) begin
            data_addr = $urandom; data_wdata = $urandom; data_we = 1'($urandom);
            data_req = 1'b1; pd = 1; ngd = n_dgnt;
         end
      end
      fetch_req = 1'b0; data_req = 1'b0;
      rand_mode = 1'b0;
      repeat (40) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mic1_mem_arbiter.md
MIC1_MEM_ARBITER -- requirements
Module: mic1_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; BYTES_PER_WORD, 4, data beats per word transfer.
REQ-002 Ports SHALL be (clock and reset first):
  clk  in  1  single system clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  fetch_req  in  1  instruction-fetch request, PC-driven
  fetch_addr  in  32  fetch byte address
  fetch_gnt  out  1  one-cycle pulse, fetch accepted
  fetch_done  out  1  one-cycle pulse, fetch_rdata valid
  fetch_rdata  out  8  fetched opcode/operand byte
  data_req  in  1  data request, MAR-driven
  data_we  in  1  1 = word write, 0 = word read
  data_addr  in  32  data word address (MAR)
  data_wdata  in  32  write word (MDR)
  data_gnt  out  1  one-cycle pulse, data access accepted
  data_done  out  1  one-cycle pulse, access complete
  data_rdata  out  32  read word
  bus_out  out  8  external byte bus, outbound
  bus_oe  out  1  1 while bus_out carries a valid byte
  bus_in  in  8  external byte bus, inbound
  bus_rd  out  1  1 while a read beat is expected on bus_in
  ext_ready  in  1  external side accepts/supplies the current beat

Function
REQ-003 Only one clock SHALL be used; reset SHALL be asynchronous, active-low.
REQ-004 A beat SHALL complete on a rising clk edge where (bus_oe or bus_rd) and ext_ready are both 1; otherwise the FSM, byte counter and bus_out SHALL hold.
REQ-005 FSM states SHALL be IDLE, CMD, ADDR, WDATA, RDATA, DONE.
REQ-006 IDLE: with no request, stay; otherwise arbitrate, latch address/we/wdata/requester, pulse the winner's gnt, go to CMD next cycle.
REQ-007 Arbitration SHALL be two-way round-robin: with a single request that requester wins; when both request, the requester not served last wins; last_served SHALL reset to data, so fetch wins the first tie.
REQ-008 CMD SHALL drive bus_out = {6'b0, word, we} (word = 1 for data, 0 for fetch) with bus_oe=1, one beat.
REQ-009 ADDR SHALL drive the latched address over 4 beats, LSB first, using a 2-bit byte counter.
REQ-010 After ADDR: data write goes to WDATA (4 beats, wdata LSB first, bus_oe=1); data read goes to RDATA for 4 beats; fetch goes to RDATA for 1 beat.
REQ-011 RDATA SHALL assert bus_rd=1 with bus_oe=0 and capture bus_in into byte lane [8*cnt+7:8*cnt] on each completed beat.
REQ-012 DONE SHALL last exactly one cycle, pulse the served requester's done, present rdata, then return to IDLE.
REQ-013 With ext_ready held 1, request seen in IDLE at cycle 0: gnt in cycle 0, done in cycle 7 (fetch) or cycle 10 (data read or write); next arbitration in cycle 8 or 11.
REQ-014 fetch_rdata and data_rdata SHALL hold their last value until the next respective done.
REQ-015 Deasserting a req after its gnt SHALL NOT abort the transaction; a requester SHALL hold req only until gnt.
REQ-016 The byte counter SHALL wrap 3->0 at each phase boundary; a new transaction SHALL always start with counter 0.
REQ-017 gnt and done SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-018 On rst_n low, asynchronously: state=IDLE, counter=0, last_served=data, all gnt/done/bus_oe/bus_rd=0, bus_out=0, fetch_rdata=0, data_rdata=0.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no done pulse; the first request after release SHALL be handled per REQ-006.

Structure
REQ-020 Package mic1_pkg SHALL hold the FSM state enum, CMD bit positions, and BYTES_PER_WORD.
REQ-021 A sub-module mic1_rr_arbiter (2 requesters, last_served register, one-hot grant) SHALL implement REQ-007.

Verification
REQ-022 Fetch 0x00000104, ext_ready=1, bus_in=0xA7 -> bus bytes 0x00,04,01,00,00; fetch_done at cycle 7 with fetch_rdata=0xA7.
REQ-023 Data write addr 0x10, wdata 0xDEADBEEF -> bytes 0x03,10,00,00,00,EF,BE,AD,DE; data_done at cycle 10.
REQ-024 Data read, bus_in sequence 0x11,22,33,44 -> data_rdata=0x44332211; ext_ready low 3 cycles mid-ADDR -> done delayed by exactly 3 cycles.
REQ-025 fetch_req and data_req both high continuously -> grants alternate fetch, data, fetch, ...
REQ-026 rst_n low during WDATA beat 2 -> all outputs at reset values immediately, no done; next fetch completes normally.
